// File: rtl/base_sram_rdpipe.sv
// Valid/ready read front-end for a 1-cycle-latency SRAM: issues a read only when its
// data is guaranteed a slot in the 2-entry output buffer, keeping responses in order.
module base_sram_rdpipe #(
  parameter int aw = 8,
  parameter int dw = 32,
  parameter int tw = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_v,
  input  logic [aw-1:0] i_a,
  input  logic [tw-1:0] i_t,
  output logic          i_r,
  output logic          sram_re,
  output logic [aw-1:0] sram_ra,
  input  logic [dw-1:0] sram_rd,
  output logic          o_v,
  output logic [dw-1:0] o_d,
  output logic [tw-1:0] o_t,
  input  logic          o_r
);

  logic          vld_p1;
  logic [tw-1:0] tag_p1;
  logic [1:0]    cnt_p2;
  logic [dw-1:0] dat_p2 [2];
  logic [tw-1:0] tgq_p2 [2];

  logic       accept;
  logic       pop;
  logic       wr_idx;
  logic [1:0] occ;

  // Stage p0: request acceptance; occupancy counts the inflight read as already buffered
  assign pop     = o_v & o_r;
  assign occ     = {1'b0, vld_p1} + cnt_p2;
  assign i_r     = ~reset & ((occ - {1'b0, pop}) < 2'd2);
  assign accept  = i_v & i_r;
  assign sram_re = accept;
  assign sram_ra = i_a;

  // Tail slot after this cycle's pop has shifted the buffer down
  assign wr_idx  = (cnt_p2 == 2'd2) || ((cnt_p2 == 2'd1) && !pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      cnt_p2 <= 2'd0;
    end else begin
      vld_p1 <= accept;
      cnt_p2 <= cnt_p2 + {1'b0, vld_p1} - {1'b0, pop};
    end
  end

  // Stage p1 -> p2: SRAM data joins its delayed tag and enters the buffer
  always_ff @(posedge clk) begin
    if (accept) tag_p1 <= i_t;
    if (pop) begin
      dat_p2[0] <= dat_p2[1];
      tgq_p2[0] <= tgq_p2[1];
    end
    if (vld_p1) begin
      dat_p2[wr_idx] <= sram_rd;
      tgq_p2[wr_idx] <= tag_p1;
    end
  end

  // Stage p2: buffer head drives the response stream
  assign o_v = (cnt_p2 != 2'd0);
  assign o_d = dat_p2[0];
  assign o_t = tgq_p2[0];

endmodule

// File: tb/tb_base_sram_rdpipe.sv
// Randomized and directed bench for base_sram_rdpipe against a queue-based
// model of outstanding requests, each response due two cycles after acceptance.
module tb_base_sram_rdpipe;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_v;
  logic [AW-1:0] i_a;
  logic [TW-1:0] i_t;
  logic          i_r;
  logic          sram_re;
  logic [AW-1:0] sram_ra;
  logic [DW-1:0] sram_rd;
  logic          o_v;
  logic [DW-1:0] o_d;
  logic [TW-1:0] o_t;
  logic          o_r;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;

  typedef struct {
    logic [DW-1:0] d;
    logic [TW-1:0] t;
    int            c;
  } ent_t;
  ent_t q[$];

  base_sram_rdpipe #(.aw(AW), .dw(DW), .tw(TW)) dut (
    .clk(clk), .reset(reset), .i_v(i_v), .i_a(i_a), .i_t(i_t), .i_r(i_r),
    .sram_re(sram_re), .sram_ra(sram_ra), .sram_rd(sram_rd),
    .o_v(o_v), .o_d(o_d), .o_t(o_t), .o_r(o_r)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
    return 32'hA5A5_0000 | {24'h0, a};
  endfunction

  // SRAM: data valid the cycle after a read, garbage otherwise
  always @(posedge clk) sram_rd <= sram_re ? mem(sram_ra) : $urandom;

  function automatic bit m_ov();
    return (q.size() > 0) && (q[0].c <= cyc_n - 2);
  endfunction

  function automatic bit m_ir();
    int pp;
    pp = (m_ov() && o_r) ? 1 : 0;
    return !reset && ((q.size() - pp) < 2);
  endfunction

  // Advance one clock, updating the model with what the handshakes did
  task automatic advance();
    bit acc, pp;
    ent_t e;
    acc = i_v & i_r;
    pp  = m_ov() & o_r;
    e.d = mem(i_a); e.t = i_t; e.c = cyc_n;
    @(posedge clk);
    if (reset) q.delete();
    else begin
      if (pp && q.size() > 0) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    @(negedge clk);
    cyc_n++;
  endtask

  task automatic test_reset();
    reset = 1; i_v = 1; i_a = 8'h01; i_t = 0; o_r = 1;
    #1;
    n_cmp++; if (i_r !== 1'b0) begin n_bad++; $display("FAIL reset_ir got %b want 0", i_r); end
    n_cmp++; if (sram_re !== 1'b0) begin n_bad++; $display("FAIL reset_re got %b want 0", sram_re); end
    advance();
    #1;
    n_cmp++; if (o_v !== 1'b0) begin n_bad++; $display("FAIL reset_ov got %b want 0", o_v); end
    n_cmp++; if (sram_re !== 1'b0) begin n_bad++; $display("FAIL reset_re2 got %b want 0", sram_re); end
    advance();
    reset = 0; i_v = 0;
    #1;
    n_cmp++; if (i_r !== 1'b1) begin n_bad++; $display("FAIL post_reset_ir got %b want 1", i_r); end
    n_cmp++; if (o_v !== 1'b0) begin n_bad++; $display("FAIL post_reset_ov got %b want 0", o_v); end
    advance();
  endtask

  task automatic test_single();
    for (int k = 0; k < 4; k++) begin
      i_v = (k == 0); i_a = 8'h05; i_t = 2'd1; o_r = 1;
      #1;
      if (k == 0) begin
        n_cmp++; if (sram_re !== 1'b1) begin n_bad++; $display("FAIL single_re got %b want 1", sram_re); end
        n_cmp++; if (sram_ra !== 8'h05) begin n_bad++; $display("FAIL single_ra got %h want 05", sram_ra); end
      end
      n_cmp++; if (o_v !== (k == 2)) begin n_bad++; $display("FAIL single_ov k=%0d got %b want %b", k, o_v, k == 2); end
      if (k == 2) begin
        n_cmp++; if (o_d !== 32'hA5A5_0005) begin n_bad++; $display("FAIL single_od got %h want a5a50005", o_d); end
        n_cmp++; if (o_t !== 2'd1) begin n_bad++; $display("FAIL single_ot got %0d want 1", o_t); end
      end
      advance();
    end
  endtask

  task automatic test_stream();
    logic [AW-1:0] ea;
    for (int k = 0; k < 19; k++) begin
      i_v = (k < 16); i_a = AW'(k); i_t = TW'(k); o_r = 1;
      #1;
      if (k < 16) begin
        n_cmp++; if (i_r !== 1'b1) begin n_bad++; $display("FAIL stream_ir k=%0d got %b want 1", k, i_r); end
      end
      n_cmp++; if (sram_re !== (k < 16)) begin n_bad++; $display("FAIL stream_re k=%0d got %b want %b", k, sram_re, k < 16); end
      n_cmp++; if (o_v !== (k >= 2 && k < 18)) begin n_bad++; $display("FAIL stream_ov k=%0d got %b", k, o_v); end
      if (k >= 2 && k < 18) begin
        ea = AW'(k - 2);
        n_cmp++; if (o_d !== mem(ea)) begin n_bad++; $display("FAIL stream_od k=%0d got %h want %h", k, o_d, mem(ea)); end
        n_cmp++; if (o_t !== TW'(k - 2)) begin n_bad++; $display("FAIL stream_ot k=%0d got %0d want %0d", k, o_t, TW'(k - 2)); end
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] na, ea;
    int pulses, rsp;
    na = 0; pulses = 0; rsp = 0; ea = 0;
    for (int k = 0; k < 5; k++) begin
      i_v = 1; i_a = na; i_t = TW'(na); o_r = 0;
      #1;
      n_cmp++; if (i_r !== (k < 2)) begin n_bad++; $display("FAIL bp_ir k=%0d got %b want %b", k, i_r, k < 2); end
      if (k >= 2) begin
        n_cmp++; if (o_v !== 1'b1) begin n_bad++; $display("FAIL bp_ov k=%0d got %b want 1", k, o_v); end
        n_cmp++; if (o_d !== mem(8'h00)) begin n_bad++; $display("FAIL bp_od k=%0d got %h want %h", k, o_d, mem(8'h00)); end
      end
      if (sram_re) begin pulses++; na++; end
      advance();
    end
    n_cmp++; if (pulses != 2) begin n_bad++; $display("FAIL bp_pulses got %0d want 2", pulses); end
    for (int k = 0; k < 5; k++) begin
      i_v = 0; o_r = 1;
      #1;
      if (k == 0) begin
        n_cmp++; if (i_r !== 1'b1) begin n_bad++; $display("FAIL bp_release_ir got %b want 1", i_r); end
      end
      if (o_v) begin
        n_cmp++; if (o_d !== mem(ea) || o_t !== TW'(ea)) begin n_bad++; $display("FAIL bp_drain got %h/%0d want %h/%0d", o_d, o_t, mem(ea), TW'(ea)); end
        ea++; rsp++;
      end
      advance();
    end
    n_cmp++; if (rsp != 2) begin n_bad++; $display("FAIL bp_drain_count got %0d want 2", rsp); end
  endtask

  task automatic test_random();
    int acc_n, rsp_n, pp;
    bit e_ov, e_ir, hold;
    logic [DW-1:0] hd;
    logic [TW-1:0] ht;
    acc_n = 0; rsp_n = 0; hold = 0; hd = 0; ht = 0;
    for (int c = 0; c < 60000 && acc_n < 10000; c++) begin
      i_v = ($urandom_range(0, 9) < 7); i_a = AW'($urandom); i_t = TW'($urandom);
      o_r = 1'($urandom_range(0, 1));
      #1;
      e_ov = m_ov(); e_ir = m_ir();
      n_cmp++; if (i_r !== e_ir) begin n_bad++; $display("FAIL rnd_ir cyc=%0d got %b want %b", cyc_n, i_r, e_ir); end
      n_cmp++; if (o_v !== e_ov) begin n_bad++; $display("FAIL rnd_ov cyc=%0d got %b want %b", cyc_n, o_v, e_ov); end
      n_cmp++; if (sram_re !== (i_v & e_ir)) begin n_bad++; $display("FAIL rnd_re cyc=%0d got %b want %b", cyc_n, sram_re, i_v & e_ir); end
      n_cmp++; if (sram_ra !== i_a) begin n_bad++; $display("FAIL rnd_ra cyc=%0d got %h want %h", cyc_n, sram_ra, i_a); end
      if (e_ov) begin
        n_cmp++; if (o_d !== q[0].d || o_t !== q[0].t) begin n_bad++; $display("FAIL rnd_resp cyc=%0d got %h/%0d want %h/%0d", cyc_n, o_d, o_t, q[0].d, q[0].t); end
      end
      if (hold) begin
        n_cmp++; if (o_v !== 1'b1 || o_d !== hd || o_t !== ht) begin n_bad++; $display("FAIL rnd_stable cyc=%0d got %b/%h/%0d want 1/%h/%0d", cyc_n, o_v, o_d, o_t, hd, ht); end
      end
      if (i_v && i_r) begin
        pp = (e_ov && o_r) ? 1 : 0;
        n_cmp++; if (q.size() - pp >= 2) begin n_bad++; $display("FAIL rnd_overflow cyc=%0d occ=%0d pop=%0d", cyc_n, q.size(), pp); end
        acc_n++;
      end
      if (o_v && o_r) rsp_n++;
      hold = o_v && !o_r; hd = o_d; ht = o_t;
      advance();
    end
    n_cmp++; if (acc_n < 10000) begin n_bad++; $display("FAIL rnd_timeout accepted %0d want 10000", acc_n); end
    for (int k = 0; k < 6; k++) begin
      i_v = 0; o_r = 1;
      #1;
      if (o_v && o_r) rsp_n++;
      advance();
    end
    n_cmp++; if (rsp_n != acc_n) begin n_bad++; $display("FAIL rnd_count got %0d responses want %0d", rsp_n, acc_n); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 2; k++) begin
      i_v = 1; i_a = AW'(8'h10 + k); i_t = TW'(k); o_r = 0;
      #1;
      advance();
    end
    reset = 1; i_v = 1; i_a = 8'h12; o_r = 0;
    #1;
    n_cmp++; if (i_r !== 1'b0) begin n_bad++; $display("FAIL rmid_ir got %b want 0", i_r); end
    n_cmp++; if (sram_re !== 1'b0) begin n_bad++; $display("FAIL rmid_re got %b want 0", sram_re); end
    advance();
    reset = 0; i_v = 0; o_r = 1;
    #1;
    n_cmp++; if (o_v !== 1'b0) begin n_bad++; $display("FAIL rmid_ov got %b want 0", o_v); end
    advance();
    for (int k = 0; k < 5; k++) begin
      i_v = (k == 0); i_a = 8'h20; i_t = 2'd1; o_r = 1;
      #1;
      n_cmp++; if (o_v !== (k == 2)) begin n_bad++; $display("FAIL rmid_post_ov k=%0d got %b want %b", k, o_v, k == 2); end
      if (k == 2) begin
        n_cmp++; if (o_d !== mem(8'h20) || o_t !== 2'd1) begin n_bad++; $display("FAIL rmid_post_resp got %h/%0d want %h/1", o_d, o_t, mem(8'h20)); end
      end
      advance();
    end
  endtask

  task automatic test_same_addr();
    for (int k = 0; k < 7; k++) begin
      i_v = (k < 4); i_a = 8'h03; i_t = TW'(k); o_r = 1;
      #1;
      n_cmp++; if (o_v !== (k >= 2 && k < 6)) begin n_bad++; $display("FAIL same_ov k=%0d got %b", k, o_v); end
      if (k >= 2 && k < 6) begin
        n_cmp++; if (o_t !== TW'(k - 2)) begin n_bad++; $display("FAIL same_ot k=%0d got %0d want %0d", k, o_t, TW'(k - 2)); end
        n_cmp++; if (o_d !== mem(8'h03)) begin n_bad++; $display("FAIL same_od k=%0d got %h want %h", k, o_d, mem(8'h03)); end
      end
      advance();
    end
  endtask

  initial begin
    reset = 1; i_v = 0; i_a = 0; i_t = 0; o_r = 0;
    @(negedge clk);
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_same_addr();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
